irq_aggr: RTL and testbench

- Parametrised interrupt aggregator between peripheral IRQ sources (native and APB wrappers, external pin) and the core's 32-bit `irq_i` vector.
- Replaces fixed hard-wired IRQ bit packing with the following per-source features:
  - edge/level mode and polarity
  - latched pending with write-1-to-clear
  - enable masking
  - a lowest-index-first claim ID register
- Software-visible through a native memory interface (valid/ready) slave port on the bus.

---
 rtl/irq_aggr_pkg.sv | 16 +
 rtl/irq_aggr_prienc.sv | 25 ++
 rtl/irq_aggr.sv | 156 +++++++++++++++
 tb/tb_irq_aggr.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_aggr_pkg.sv
// irq_aggr_pkg: register map and claim-register layout
// shared by the interrupt aggregator and its priority encoder.
package irq_aggr_pkg;

    localparam int unsigned OFF_PEND      = 32'h00;
    localparam int unsigned OFF_EN        = 32'h04;
    localparam int unsigned OFF_MODE      = 32'h08;
    localparam int unsigned OFF_POL       = 32'h0C;
    localparam int unsigned OFF_RAW       = 32'h10;
    localparam int unsigned OFF_CLAIM     = 32'h14;
    localparam int unsigned OFF_CLAIM_CLR = 32'h18;

    localparam int CLAIM_VLD_BIT = 31;
    localparam int CLAIM_IDX_W   = 5;

endpackage

// File: rtl/irq_aggr_prienc.sv
// irq_aggr_prienc: combinational lowest-index-first priority
// encoder returning {valid, idx} over N request bits.
module irq_aggr_prienc
    import irq_aggr_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]             req,
    output logic                     valid,
    output logic [CLAIM_IDX_W-1:0]   idx
);

    // scan from the top so the lowest set index is written last
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = CLAIM_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_aggr.sv
// irq_aggr: per-source edge/level interrupt aggregator with a
// valid/ready register port. IRQ_AGGR_SYNC_EN adds a 2-flop src sync.
module irq_aggr
    import irq_aggr_pkg::*;
#(
    parameter int NUM_SRC  = 16,
    parameter int IRQ_BASE = 5,
    parameter int ADDR_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               mem_valid_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [31:0]        mem_wdata_i,
    input  logic [3:0]         mem_wstrb_i,
    output logic               mem_ready_o,
    output logic [31:0]        mem_rdata_o,
    output logic [31:0]        irq_o
);

    logic [NUM_SRC-1:0] samp_d, samp, prev, pend, en, mode, pol, q;
    logic [NUM_SRC-1:0] en_nxt, mode_nxt, pol_nxt;
    logic [NUM_SRC-1:0] pend_nxt, prev_nxt, clr, bm, wd;
    logic [31:0]        bm32, rd, irq_nxt;
    logic [ADDR_W-1:0]  waddr;
    logic               acc, wr;
    logic               sel_pend, sel_en, sel_mode, sel_pol;
    logic               sel_raw, sel_claim, sel_cclr;
    logic               claim_v;
    logic [CLAIM_IDX_W-1:0] claim_idx;
    logic               unused;

`ifdef IRQ_AGGR_SYNC_EN
    logic [NUM_SRC-1:0] sync1, sync2;

    // first synchroniser stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync1 <= '0;
        else       sync1 <= src_i;
    end

    // second synchroniser stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync2 <= '0;
        else       sync2 <= sync1;
    end

    assign samp_d = sync2;
`else
    assign samp_d = src_i;
`endif

    assign unused = ^{mem_addr_i[1:0], mem_wdata_i};

    assign waddr = {mem_addr_i[ADDR_W-1:2], 2'b00};
    assign acc   = mem_valid_i & ~mem_ready_o;
    assign wr    = acc & (|mem_wstrb_i);

    assign sel_pend  = waddr == ADDR_W'(OFF_PEND);
    assign sel_en    = waddr == ADDR_W'(OFF_EN);
    assign sel_mode  = waddr == ADDR_W'(OFF_MODE);
    assign sel_pol   = waddr == ADDR_W'(OFF_POL);
    assign sel_raw   = waddr == ADDR_W'(OFF_RAW);
    assign sel_claim = waddr == ADDR_W'(OFF_CLAIM);
    assign sel_cclr  = waddr == ADDR_W'(OFF_CLAIM_CLR);

    assign bm32 = {{8{mem_wstrb_i[3]}}, {8{mem_wstrb_i[2]}},
                   {8{mem_wstrb_i[1]}}, {8{mem_wstrb_i[0]}}};
    assign bm   = bm32[NUM_SRC-1:0];
    assign wd   = mem_wdata_i[NUM_SRC-1:0];

    assign q = samp ^ pol;

    irq_aggr_prienc #(
        .N (NUM_SRC)
    ) u_prienc (
        .req   (pend & en),
        .valid (claim_v),
        .idx   (claim_idx)
    );

    // next config/pending state; edge set beats a same-cycle clear
    always_comb begin
        en_nxt   = (wr & sel_en)   ? ((en & ~bm) | (wd & bm))   : en;
        mode_nxt = (wr & sel_mode) ? ((mode & ~bm) | (wd & bm)) : mode;
        pol_nxt  = (wr & sel_pol)  ? ((pol & ~bm) | (wd & bm))  : pol;
        clr      = (wr & sel_pend) ? (wd & bm) : '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (wr && sel_cclr &&
                mem_wdata_i[CLAIM_IDX_W-1:0] == CLAIM_IDX_W'(i))
                clr[i] = 1'b1;
        end
        pend_nxt = (mode & ((q & ~prev) | (pend & ~clr))) | (~mode & q);
        prev_nxt = (wr & (sel_mode | sel_pol)) ? (samp_d ^ pol_nxt) : q;
        irq_nxt  = '0;
        irq_nxt[IRQ_BASE +: NUM_SRC] = pend_nxt & en_nxt;
    end

    // register read mux, sampled before any same-access write
    always_comb begin
        rd = '0;
        unique case (1'b1)
            sel_pend:  rd = 32'(pend);
            sel_en:    rd = 32'(en);
            sel_mode:  rd = 32'(mode);
            sel_pol:   rd = 32'(pol);
            sel_raw:   rd = 32'(q);
            sel_claim: begin
                rd[CLAIM_VLD_BIT]     = claim_v;
                rd[CLAIM_IDX_W-1:0]   = claim_idx;
            end
            default:   rd = '0;
        endcase
    end

    // source sampling, edge history, pending and irq vector
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            samp  <= '0;
            prev  <= '0;
            pend  <= '0;
            irq_o <= '0;
        end else begin
            samp  <= samp_d;
            prev  <= prev_nxt;
            pend  <= pend_nxt;
            irq_o <= irq_nxt;
        end
    end

    // software configuration registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en   <= '0;
            mode <= '0;
            pol  <= '0;
        end else begin
            en   <= en_nxt;
            mode <= mode_nxt;
            pol  <= pol_nxt;
        end
    end

    // single-cycle ready pulse and read data return
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_ready_o <= 1'b0;
            mem_rdata_o <= '0;
        end else begin
            mem_ready_o <= acc;
            mem_rdata_o <= acc ? rd : '0;
        end
    end

endmodule

// File: tb/tb_irq_aggr.sv
// tb_irq_aggr: directed plus randomized checks of irq_aggr against
// a bit-per-source reference model of pending/enable/claim behaviour.
module tb_irq_aggr;

    localparam int NS   = 16;
    localparam int BASE = 5;
    localparam bit [31:0] MASK = 32'h0000_FFFF;
`ifdef IRQ_AGGR_SYNC_EN
    localparam int XTRA = 2;
`else
    localparam int XTRA = 0;
`endif

    localparam logic [7:0] A_PEND = 8'h00;
    localparam logic [7:0] A_EN   = 8'h04;
    localparam logic [7:0] A_MODE = 8'h08;
    localparam logic [7:0] A_POL  = 8'h0C;
    localparam logic [7:0] A_RAW  = 8'h10;
    localparam logic [7:0] A_CLM  = 8'h14;
    localparam logic [7:0] A_CCLR = 8'h18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] src_a;
    logic [31:0] src_b;
    logic        valid_a, valid_b;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready_a, ready_b;
    logic [31:0] rdata_a, rdata_b, irq_a, irq_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    irq_aggr #(.NUM_SRC(16), .IRQ_BASE(5), .ADDR_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .src_i       (src_a),
        .mem_valid_i (valid_a),
        .mem_addr_i  (addr),
        .mem_wdata_i (wdata),
        .mem_wstrb_i (wstrb),
        .mem_ready_o (ready_a),
        .mem_rdata_o (rdata_a),
        .irq_o       (irq_a)
    );

    irq_aggr #(.NUM_SRC(32), .IRQ_BASE(0), .ADDR_W(8)) dut32 (
        .clk_i       (clk),
        .rst_i       (rst),
        .src_i       (src_b),
        .mem_valid_i (valid_b),
        .mem_addr_i  (addr),
        .mem_wdata_i (wdata),
        .mem_wstrb_i (wstrb),
        .mem_ready_o (ready_b),
        .mem_rdata_o (rdata_b),
        .irq_o       (irq_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [31:0] m_pend = 0, m_en = 0, m_mode = 0, m_pol = 0;
    bit [31:0] m_samp = 0, m_prev = 0, m_irq = 0, m_rdata = 0;
    bit        m_ready = 0;
`ifdef IRQ_AGGR_SYNC_EN
    bit [31:0] m_s1 = 0, m_s2 = 0;
`endif

    function automatic bit [31:0] m_claim();
        for (int i = 0; i < NS; i++)
            if (m_pend[i] && m_en[i]) return 32'h8000_0000 | i;
        return 32'h0;
    endfunction

    function automatic bit [31:0] m_read(input bit [5:0] wa,
                                         input bit [31:0] q);
        case (wa)
            6'd0:    return m_pend;
            6'd1:    return m_en;
            6'd2:    return m_mode;
            6'd3:    return m_pol;
            6'd4:    return q;
            6'd5:    return m_claim();
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        bit        acc, wr, pmw;
        bit [5:0]  wa;
        bit [31:0] q, bm, clr, nx, sn;
        acc = valid_a && !m_ready;
        wr  = acc && (wstrb != 4'h0);
        wa  = addr[7:2];
        q   = (m_samp ^ m_pol) & MASK;
        m_rdata = acc ? m_read(wa, q) : 32'h0;
        bm  = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
        clr = 0;
        if (wr && wa == 0) clr = wdata & bm;
        if (wr && wa == 6 && wdata[4:0] < NS) clr[wdata[4:0]] = 1'b1;
        nx = 0;
        for (int i = 0; i < NS; i++)
            nx[i] = m_mode[i] ? ((q[i] && !m_prev[i]) ||
                                 (m_pend[i] && !clr[i])) : q[i];
        if (wr && wa == 1) m_en   = ((m_en & ~bm) | (wdata & bm)) & MASK;
        if (wr && wa == 2) m_mode = ((m_mode & ~bm) | (wdata & bm)) & MASK;
        if (wr && wa == 3) m_pol  = ((m_pol & ~bm) | (wdata & bm)) & MASK;
        pmw = wr && (wa == 2 || wa == 3);
`ifdef IRQ_AGGR_SYNC_EN
        sn   = m_s2;
        m_s2 = m_s1;
        m_s1 = {16'h0, src_a};
`else
        sn = {16'h0, src_a};
`endif
        m_prev  = pmw ? ((sn ^ m_pol) & MASK) : q;
        m_pend  = nx;
        m_samp  = sn;
        m_irq   = (m_pend & m_en) << BASE;
        m_ready = acc;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pend = 0; m_en = 0; m_mode = 0; m_pol = 0;
            m_samp = 0; m_prev = 0; m_irq = 0; m_rdata = 0;
            m_ready = 0;
`ifdef IRQ_AGGR_SYNC_EN
            m_s1 = 0; m_s2 = 0;
`endif
        end else begin
            model_step();
        end
    end

    // every-cycle compare of the main instance against the model
    always @(posedge clk) begin
        #1;
        check("mon_irq", irq_a, m_irq);
        check("mon_rdy", {31'b0, ready_a}, {31'b0, m_ready});
        if (m_ready) check("mon_rdata", rdata_a, m_rdata);
    end

    // ---------------- bus helpers ----------------
    task automatic bus(input bit sel, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd);
        int   n;
        logic r;
        @(negedge clk);
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        addr = a; wdata = d; wstrb = s;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            r = sel ? ready_b : ready_a;
        end while (!r && n < 8);
        check("bus_ready", {31'b0, r}, 32'h1);
        rd = sel ? rdata_b : rdata_a;
        @(negedge clk);
        valid_a = 1'b0; valid_b = 1'b0; wstrb = 4'h0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(1'b0, a, d, 4'hF, dummy);
    endtask

    task automatic rdc(input string tag, input logic [7:0] a,
                       input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, a, 32'h0, 4'h0, v);
        check(tag, v, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        int k;
        src_a = 0; src_b = 0; valid_a = 0; valid_b = 0;
        addr = 0; wdata = 0; wstrb = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", irq_a, 32'h0);
        check("rst_rdy", {31'b0, ready_a}, 32'h0);
        @(negedge clk) rst = 1'b0;
        rdc("rst_en", A_EN, 32'h0);

        // reset pulsed during an EN write
        @(negedge clk);
        valid_a = 1'b1; addr = A_EN; wdata = 32'hFFFF; wstrb = 4'hF;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_rdy", {31'b0, ready_a}, 32'h0);
        @(negedge clk);
        rst = 1'b0; valid_a = 1'b0; wstrb = 4'h0;
        rdc("midrst_en", A_EN, 32'h0);
        check("midrst_irq", irq_a, 32'h0);

        // edge mode on source 3
        wr(A_MODE, 32'h8);
        wr(A_EN, 32'h8);
        @(negedge clk) src_a = 16'h8;
        @(posedge clk); #1;
        check("edge_early", {31'b0, irq_a[8]}, 32'h0);
        @(negedge clk) src_a = 16'h0;
        repeat (XTRA) @(posedge clk);
        @(posedge clk); #1;
        check("edge_irq", {31'b0, irq_a[8]}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("edge_hold", {31'b0, irq_a[8]}, 32'h1);
        wr(A_PEND, 32'h8);
        @(posedge clk); #1;
        check("edge_w1c", {31'b0, irq_a[8]}, 32'h0);

        // level mode, inverted polarity on source 0
        wr(A_MODE, 32'h0);
        wr(A_POL, 32'h1);
        wr(A_EN, 32'h1);
        repeat (3 + XTRA) @(posedge clk);
        #1;
        check("lvl_act", irq_a, 32'h20);
        @(negedge clk) src_a = 16'h1;
        repeat (2 + XTRA) @(posedge clk);
        #1;
        check("lvl_clr", irq_a, 32'h0);
        @(negedge clk) src_a = 16'h0;
        repeat (3 + XTRA) @(posedge clk);
        wr(A_PEND, 32'h1);
        rdc("lvl_w1c", A_PEND, 32'h1);

        // edge and W1C colliding on source 2
        wr(A_POL, 32'h0);
        wr(A_MODE, 32'h4);
        wr(A_EN, 32'h4);
        repeat (2 + XTRA) @(posedge clk);
        @(negedge clk) src_a = 16'h4;
        repeat (XTRA) @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b1; addr = A_PEND; wdata = 32'h4; wstrb = 4'hF;
        @(posedge clk); #1;
        check("coll_rdy", {31'b0, ready_a}, 32'h1);
        @(negedge clk);
        valid_a = 1'b0; wstrb = 4'h0; src_a = 16'h0;
        rdc("coll_pend", A_PEND, 32'h4);

        // claim and claim-clear
        wr(A_MODE, 32'h0A);
        wr(A_EN, 32'h08);
        @(negedge clk) src_a = 16'h0A;
        @(negedge clk) src_a = 16'h00;
        repeat (3 + XTRA) @(posedge clk);
        rdc("clm_pend", A_PEND, 32'h0A);
        rdc("clm_val", A_CLM, 32'h8000_0003);
        bus(1'b0, A_CCLR, 32'd3, 4'h1, v);
        rdc("clm_after", A_CLM, 32'h0);
        rdc("clm_pend2", A_PEND, 32'h02);
        bus(1'b0, A_CCLR, 32'd20, 4'h1, v);
        rdc("clm_oob", A_PEND, 32'h02);

        // back-to-back RAW reads with valid held
        @(negedge clk) src_a = 16'h5;
        repeat (3 + XTRA) @(posedge clk);
        @(negedge clk);
        valid_a = 1'b1; addr = A_RAW; wstrb = 4'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("b2b_rdy", {31'b0, ready_a}, (i % 2 == 0) ? 32'h1 : 32'h0);
            if (ready_a) check("b2b_raw", rdata_a, 32'h5);
        end
        @(negedge clk) valid_a = 1'b0;
        rdc("unmapped", 8'h40, 32'h0);

        // 32-source, base-0 instance: source 31 edge
        bus(1'b1, A_MODE, 32'h8000_0000, 4'hF, v);
        bus(1'b1, A_EN, 32'h8000_0000, 4'hF, v);
        @(negedge clk) src_b = 32'h8000_0000;
        @(negedge clk) src_b = 32'h0;
        repeat (XTRA) @(posedge clk);
        @(posedge clk); #1;
        check("w32_irq", irq_b, 32'h8000_0000);
        bus(1'b1, A_CLM, 32'h0, 4'h0, v);
        check("w32_claim", v, 32'h8000_001F);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 3);
            if (k == 0) begin
                @(negedge clk) src_a = 16'($urandom);
            end else begin
                k = $urandom_range(0, 8);
                bus(1'b0, (k == 8) ? 8'h40 : 8'(k * 4),
                    ($urandom_range(0, 1) != 0) ? $urandom
                                                : 32'($urandom_range(0, 31)),
                    ($urandom_range(0, 2) == 0) ? 4'h0
                                                : 4'($urandom_range(1, 15)),
                    v);
            end
        end

        repeat (4) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
